spi_yanitlayici: RTL and testbench
==================================

SPI_YANITLAYICI -- requirements
Module: spi_yanitlayici

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flop count of each input synchronizer, minimum 2.
REQ-002 SHALL have port clk_i, input, 1: the only clock.
REQ-003 SHALL have port rst_i, input, 1: synchronous reset, active-high.
REQ-004 SHALL have port cfg_cpol_i, input, 1: SCK idle level; captured at CSN assertion.
REQ-005 SHALL have port cfg_cpha_i, input, 1: clock phase; captured at CSN assertion.
REQ-006 SHALL have port cfg_msb_first_i, input, 1: bit order; captured at CSN assertion.
REQ-007 SHALL have port tx_data_i, input, `SPI_TXN_SIZE: word to return on MISO.
REQ-008 SHALL have port tx_valid_i, input, 1: tx_data_i valid.
REQ-009 SHALL have port tx_ready_o, output, 1: holding register empty.
REQ-010 SHALL have port rx_data_o, output, `SPI_TXN_SIZE: last complete received word.
REQ-011 SHALL have port rx_valid_o, output, 1: one-cycle pulse per complete word.
REQ-012 SHALL have port txn_abort_o, output, 1: one-cycle pulse when CSN deasserts mid-word.
REQ-013 SHALL have ports sck_i, csn_i, mosi_i (input, 1 each): asynchronous SPI pins from the initiator.
REQ-014 SHALL have ports miso_o and miso_oe_o (output, 1 each): serial data and its tri-state enable.

Function
REQ-015 SHALL pass sck_i, csn_i, mosi_i through SYNC_STAGES-flop synchronizers; all edge detection uses synchronized values. Correct operation requires an SCK period of at least 8 clk_i cycles.
REQ-016 SHALL implement states BOSTA, AKTAR and BEKLE. Transitions:
- BOSTA->AKTAR on the synchronized CSN falling edge.
- AKTAR->BEKLE when a word completes.
- BEKLE->AKTAR on the next leading SCK edge while CSN is low.
- Any state->BOSTA on the synchronized CSN rising edge.
REQ-017 SHALL define the leading edge as an SCK transition away from the captured cpol and the trailing edge as the return transition.
REQ-018 SHALL sample MOSI on the leading edge and shift MISO on the trailing edge when cpha=0; when cpha=1, SHALL shift on the leading edge and sample on the trailing edge.
REQ-019 SHALL load the MISO shift register at CSN assertion and at each word boundary: from the holding register if it is full (then mark it empty), otherwise with all zeros.
REQ-020 When cpha=0, SHALL drive the first bit on miso_o in the cycle after the CSN falling-edge detection.
REQ-021 SHALL transmit and assemble bit 0 first when msb_first=0, and bit `SPI_TXN_SIZE-1 first when msb_first=1.
REQ-022 SHALL count samples 0..`SPI_TXN_SIZE-1. On the last sample it SHALL wrap the count to 0, update rx_data_o, and pulse rx_valid_o in the following cycle.
REQ-023 SHALL keep consecutive words under one continuous CSN assertion gap-free, reloading per REQ-019.
REQ-024 SHALL hold tx_ready_o high while the holding register is empty and accept a word when tx_valid_i and tx_ready_o are both high.
REQ-025 If a reload and an accept fall in the same cycle, the reload SHALL use the holding register's pre-cycle state and the accepted word SHALL be written to the holding register.
REQ-026 SHALL respond to CSN deassertion with a nonzero, incomplete bit count as follows: discard the partial word, keep rx_data_o unchanged, suppress rx_valid_o, pulse txn_abort_o, and return to BOSTA. An unconsumed holding word is retained.
REQ-027 SHALL hold miso_oe_o high exactly while synchronized CSN is low; while miso_oe_o is low, miso_o SHALL be 0.
REQ-028 SHALL ignore SCK edges while CSN is high.

Reset
REQ-029 SHALL, on rst_i high at a clk_i edge, enter BOSTA and set the following:
- outputs: tx_ready_o=1, rx_data_o=0, rx_valid_o=0, txn_abort_o=0, miso_o=0, miso_oe_o=0;
- synchronizers preset to CSN=1, SCK=0, MOSI=0;
- holding register empty.
REQ-030 SHALL, on reset asserted mid-transfer, drop the transfer with no rx_valid_o and no txn_abort_o pulse.

Structure
REQ-031 SHALL take `SPI_TXN_SIZE, `HIGH and `LOW from sabitler.vh; state encodings SHALL be local constants.
REQ-032 SHALL instantiate one sub-module, senkronlayici (parameterized width, depth, and reset value), once for the three inputs.

Verification
REQ-033 Mode 0, MSB-first, tx 0xA5A5_0F0F preloaded, initiator sends 0x1234_5678 at clk/32 -> rx_data_o=0x1234_5678 with one rx_valid_o pulse, and MISO stream equals 0xA5A5_0F0F.
REQ-034 Modes 1, 2, and 3, LSB-first, word 0xDEAD_BEEF looped both ways -> exact match in each mode.
REQ-035 Two back-to-back words with CSN held low, second tx word written during the first -> two rx_valid_o pulses, and the second MISO word is correct.
REQ-036 No tx word loaded -> MISO all zeros and tx_ready_o stays 1.
REQ-037 CSN raised after 13 bits -> txn_abort_o pulses once, no rx_valid_o, rx_data_o unchanged; the next full word is received correctly.
REQ-038 rst_i asserted after 20 bits -> all outputs at reset values next cycle; a following transfer passes.

Source files
------------

// File: rtl/spi_yanitlayici_pkg.sv
// Types and bit-order helpers for the SPI responder.
`include "sabitler.vh"

package spi_yanitlayici_pkg;

    localparam int TXN_W = `SPI_TXN_SIZE;
    localparam int CNT_W = $clog2(TXN_W);

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic msb_first;
    } spi_cfg_t;

    // Bit that goes out next on MISO for the given bit order.
    function automatic logic out_bit(input logic [TXN_W-1:0] w, input logic msb);
        return msb ? w[TXN_W-1] : w[0];
    endfunction

    function automatic logic [TXN_W-1:0] shift_word(input logic [TXN_W-1:0] w, input logic msb);
        return msb ? {w[TXN_W-2:0], `LOW} : {`LOW, w[TXN_W-1:1]};
    endfunction

endpackage

// File: rtl/sabitler.vh
// Shared SPI constants: transaction width and logic level aliases.
`ifndef SABITLER_VH
`define SABITLER_VH
`define SPI_TXN_SIZE 32
`define HIGH 1'b1
`define LOW  1'b0
`endif

// File: rtl/senkronlayici.sv
// Multi-flop synchronizer for asynchronous pins, with a per-bit reset value.
module senkronlayici #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk_i) begin
        if (rst_i) pipe <= {DEPTH{RST_VAL}};
        else       pipe <= {pipe[DEPTH-2:0], d_i};
    end

    assign q_o = pipe[DEPTH-1];

endmodule

// File: rtl/spi_yanitlayici.sv
// SPI target: oversampled SCK/CSN/MOSI, all four modes, selectable bit order,
// single-word holding register for MISO data.
module spi_yanitlayici
    import spi_yanitlayici_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_cpol_i,
    input  logic                     cfg_cpha_i,
    input  logic                     cfg_msb_first_i,
    input  logic [`SPI_TXN_SIZE-1:0] tx_data_i,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    output logic [`SPI_TXN_SIZE-1:0] rx_data_o,
    output logic                     rx_valid_o,
    output logic                     txn_abort_o,
    input  logic                     sck_i,
    input  logic                     csn_i,
    input  logic                     mosi_i,
    output logic                     miso_o,
    output logic                     miso_oe_o
);

    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] AKTAR = 2'd1;
    localparam logic [1:0] BEKLE = 2'd2;

    logic [2:0]       pins_s;
    logic             sck_s, csn_s, mosi_s;
    logic             sck_q, csn_q;
    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    spi_cfg_t         cfg_q;
    logic [TXN_W-1:0] rx_sh, rx_next;
    logic [TXN_W-1:0] tx_sh, load_word;
    logic [TXN_W-1:0] hold_data;
    logic             hold_full;
    logic             miso_q;

    // Pin order {mosi, csn, sck}; CSN presets high so reset looks idle.
    senkronlayici #(
        .WIDTH  (3),
        .DEPTH  (SYNC_STAGES),
        .RST_VAL({`LOW, `HIGH, `LOW})
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({mosi_i, csn_i, sck_i}),
        .q_o   (pins_s)
    );

    assign sck_s  = pins_s[0];
    assign csn_s  = pins_s[1];
    assign mosi_s = pins_s[2];

    logic csn_fall, csn_rise, sck_edge, active;
    logic lead_ev, trail_ev, sample_ev, shift_ev, last_bit, word_done, reload;

    assign csn_fall  = csn_q & ~csn_s;
    assign csn_rise  = ~csn_q & csn_s;
    assign sck_edge  = sck_s ^ sck_q;
    assign active    = (state != BOSTA) & ~csn_s;
    assign lead_ev   = active & sck_edge & (sck_s != cfg_q.cpol);
    assign trail_ev  = active & sck_edge & (sck_s == cfg_q.cpol);
    assign sample_ev = cfg_q.cpha ? trail_ev : lead_ev;
    assign shift_ev  = cfg_q.cpha ? lead_ev : trail_ev;
    assign last_bit  = (bit_cnt == CNT_W'(TXN_W - 1));
    assign word_done = sample_ev & last_bit;
    assign reload    = csn_fall | word_done;
    assign load_word = hold_full ? hold_data : '0;
    assign rx_next   = cfg_q.msb_first ? {rx_sh[TXN_W-2:0], mosi_s}
                                       : {mosi_s, rx_sh[TXN_W-1:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q       <= `LOW;
            csn_q       <= `HIGH;
            state       <= BOSTA;
            bit_cnt     <= '0;
            cfg_q       <= '0;
            rx_sh       <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= `LOW;
            txn_abort_o <= `LOW;
        end else begin
            sck_q       <= sck_s;
            csn_q       <= csn_s;
            rx_valid_o  <= `LOW;
            txn_abort_o <= `LOW;
            if (csn_rise) begin
                state   <= BOSTA;
                bit_cnt <= '0;
                if (state != BOSTA && bit_cnt != '0) txn_abort_o <= `HIGH;
            end else if (csn_fall) begin
                state   <= AKTAR;
                bit_cnt <= '0;
                cfg_q   <= {cfg_cpol_i, cfg_cpha_i, cfg_msb_first_i};
            end else if (sample_ev) begin
                rx_sh <= rx_next;
                if (last_bit) begin
                    bit_cnt    <= '0;
                    rx_data_o  <= rx_next;
                    rx_valid_o <= `HIGH;
                    state      <= BEKLE;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    state   <= AKTAR;
                end
            end else if (lead_ev && state == BEKLE) begin
                state <= AKTAR;
            end
        end
    end

    // cpha=0 puts the first bit out at CSN assertion; cpha=1 waits for the
    // first leading edge. A word boundary reloads without shifting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_sh  <= '0;
            miso_q <= `LOW;
        end else if (csn_fall) begin
            if (cfg_cpha_i) begin
                tx_sh <= load_word;
            end else begin
                miso_q <= out_bit(load_word, cfg_msb_first_i);
                tx_sh  <= shift_word(load_word, cfg_msb_first_i);
            end
        end else if (word_done) begin
            tx_sh <= load_word;
        end else if (shift_ev) begin
            miso_q <= out_bit(tx_sh, cfg_q.msb_first);
            tx_sh  <= shift_word(tx_sh, cfg_q.msb_first);
        end
    end

    // Accept only when empty, so a same-cycle reload already saw "empty".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_full <= `LOW;
            hold_data <= '0;
        end else if (tx_valid_i && !hold_full) begin
            hold_full <= `HIGH;
            hold_data <= tx_data_i;
        end else if (reload && hold_full) begin
            hold_full <= `LOW;
        end
    end

    assign tx_ready_o = ~hold_full;
    assign miso_oe_o  = ~csn_s;
    assign miso_o     = miso_oe_o & miso_q;

endmodule

// File: tb/tb_spi_yanitlayici.sv
// Scoreboard bench: directed SPI transfers, expected rx words queued at issue
// and popped by a monitor on each rx_valid_o pulse.
module tb_spi_yanitlayici;
    import spi_yanitlayici_pkg::*;

    localparam int H = 16;  // half SCK period in clk cycles (clk/32)

    logic             clk_i = 0;
    logic             rst_i = 1;
    logic             cfg_cpol_i = 0, cfg_cpha_i = 0, cfg_msb_first_i = 1;
    logic [TXN_W-1:0] tx_data_i = '0;
    logic             tx_valid_i = 0;
    logic             tx_ready_o;
    logic [TXN_W-1:0] rx_data_o;
    logic             rx_valid_o, txn_abort_o;
    logic             sck_i = 0, csn_i = 1, mosi_i = 0;
    logic             miso_o, miso_oe_o;

    spi_yanitlayici #(.SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_cpol_i(cfg_cpol_i), .cfg_cpha_i(cfg_cpha_i), .cfg_msb_first_i(cfg_msb_first_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .txn_abort_o(txn_abort_o),
        .sck_i(sck_i), .csn_i(csn_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, failures = 0;
    int rx_pulses = 0, abort_cnt = 0;
    logic [TXN_W-1:0] exp_rx[$];
    logic [TXN_W-1:0] mosi_w[2];
    logic [TXN_W-1:0] miso_w[2];

    task automatic check(input string name, input logic [TXN_W-1:0] act, input logic [TXN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            rx_pulses++;
            checks++;
            if (exp_rx.size() == 0) begin
                failures++;
                $display("FAIL rx_unexpected got=%h exp=none", rx_data_o);
            end else begin
                logic [TXN_W-1:0] e;
                e = exp_rx.pop_front();
                if (rx_data_o !== e) begin
                    failures++;
                    $display("FAIL rx_word got=%h exp=%h", rx_data_o, e);
                end
            end
        end
        if (txn_abort_o) abort_cnt++;
    end

    task automatic write_tx(input logic [TXN_W-1:0] d);
        int n = 0;
        while (!tx_ready_o && n < 2000) begin wait_clk(1); n++; end
        if (!tx_ready_o) begin
            checks++; failures++;
            $display("FAIL tx_ready_timeout got=0 exp=1");
        end
        tx_data_i = d; tx_valid_i = 1;
        wait_clk(1);
        tx_valid_i = 0;
    endtask

    // Initiator: drives nbits across mosi_w[], captures MISO into miso_w[].
    task automatic spi_xfer(input logic cpol, input logic cpha, input logic msb,
                            input int nbits, input bit raise);
        sck_i = cpol;
        wait_clk(H);
        csn_i = 0;
        for (int i = 0; i < nbits; i++) begin
            int w, p;
            w = i / TXN_W;
            p = msb ? TXN_W - 1 - (i % TXN_W) : i % TXN_W;
            if (!cpha) mosi_i = mosi_w[w][p];
            wait_clk(H);
            sck_i = ~cpol;
            if (!cpha) miso_w[w][p] = miso_o;
            else       mosi_i = mosi_w[w][p];
            wait_clk(H);
            sck_i = cpol;
            if (cpha) miso_w[w][p] = miso_o;
        end
        wait_clk(H);
        if (raise) begin
            csn_i = 1; mosi_i = 0;
            wait_clk(H);
        end
    endtask

    task automatic set_cfg(input logic cpol, input logic cpha, input logic msb);
        cfg_cpol_i = cpol; cfg_cpha_i = cpha; cfg_msb_first_i = msb;
        sck_i = cpol;
        wait_clk(4);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ab0, rx0;
        wait_clk(3);
        rst_i = 0;
        @(negedge clk_i);
        check("rst_tx_ready", tx_ready_o, 1);
        check("rst_rx_data", rx_data_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_abort", txn_abort_o, 0);
        check("rst_miso", miso_o, 0);
        check("rst_miso_oe", miso_oe_o, 0);

        // mode 0, MSB first
        set_cfg(0, 0, 1);
        write_tx(32'hA5A5_0F0F);
        check("hold_full_ready", tx_ready_o, 0);
        mosi_w[0] = 32'h1234_5678;
        exp_rx.push_back(32'h1234_5678);
        spi_xfer(0, 0, 1, 32, 1);
        check("m0_miso", miso_w[0], 32'hA5A5_0F0F);
        check("m0_rx_data", rx_data_o, 32'h1234_5678);
        check("m0_idle_oe", miso_oe_o, 0);

        // modes 1..3, LSB first, loopback word
        for (int m = 1; m < 4; m++) begin
            logic [1:0] mb;
            mb = m[1:0];
            set_cfg(mb[1], mb[0], 0);
            write_tx(32'hDEAD_BEEF);
            mosi_w[0] = 32'hDEAD_BEEF;
            exp_rx.push_back(32'hDEAD_BEEF);
            spi_xfer(mb[1], mb[0], 0, 32, 1);
            check($sformatf("mode%0d_miso", m), miso_w[0], 32'hDEAD_BEEF);
            check($sformatf("mode%0d_rx", m), rx_data_o, 32'hDEAD_BEEF);
        end

        // two words under one CSN, second tx written mid first word
        set_cfg(0, 0, 1);
        write_tx(32'h0BAD_F00D);
        mosi_w[0] = 32'hCAFE_BABE;
        mosi_w[1] = 32'h1357_9BDF;
        exp_rx.push_back(32'hCAFE_BABE);
        exp_rx.push_back(32'h1357_9BDF);
        rx0 = rx_pulses;
        fork
            spi_xfer(0, 0, 1, 64, 1);
            begin wait_clk(200); write_tx(32'h600D_C0DE); end
        join
        check("b2b_miso0", miso_w[0], 32'h0BAD_F00D);
        check("b2b_miso1", miso_w[1], 32'h600D_C0DE);
        check("b2b_pulses", rx_pulses - rx0, 2);

        // nothing loaded: zeros out, ready stays high
        set_cfg(1, 1, 1);
        check("empty_ready_pre", tx_ready_o, 1);
        mosi_w[0] = 32'h89AB_CDEF;
        exp_rx.push_back(32'h89AB_CDEF);
        spi_xfer(1, 1, 1, 32, 1);
        check("empty_miso", miso_w[0], 32'h0);
        check("empty_ready_post", tx_ready_o, 1);

        // abort after 13 bits, then a clean word
        set_cfg(0, 0, 1);
        ab0 = abort_cnt; rx0 = rx_pulses;
        mosi_w[0] = 32'hFFFF_FFFF;
        spi_xfer(0, 0, 1, 13, 1);
        wait_clk(8);
        check("abort_pulses", abort_cnt - ab0, 1);
        check("abort_no_rx", rx_pulses - rx0, 0);
        check("abort_rx_kept", rx_data_o, 32'h89AB_CDEF);
        mosi_w[0] = 32'h2468_ACE0;
        exp_rx.push_back(32'h2468_ACE0);
        spi_xfer(0, 0, 1, 32, 1);
        check("post_abort_rx", rx_data_o, 32'h2468_ACE0);

        // reset mid-transfer with a full holding register
        write_tx(32'h1111_1111);
        ab0 = abort_cnt; rx0 = rx_pulses;
        mosi_w[0] = 32'h3333_3333;
        spi_xfer(0, 0, 1, 20, 0);
        write_tx(32'h2222_2222);
        check("midrst_hold_full", tx_ready_o, 0);
        rst_i = 1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
        check("midrst_tx_ready", tx_ready_o, 1);
        check("midrst_rx_data", rx_data_o, 0);
        check("midrst_rx_valid", rx_valid_o, 0);
        check("midrst_abort", txn_abort_o, 0);
        check("midrst_miso", miso_o, 0);
        check("midrst_miso_oe", miso_oe_o, 0);
        wait_clk(4);
        csn_i = 1; mosi_i = 0;
        wait_clk(H);
        check("midrst_no_abort", abort_cnt - ab0, 0);
        check("midrst_no_rx", rx_pulses - rx0, 0);

        set_cfg(0, 1, 1);
        write_tx(32'h5A5A_5A5A);
        mosi_w[0] = 32'hF00D_FACE;
        exp_rx.push_back(32'hF00D_FACE);
        spi_xfer(0, 1, 1, 32, 1);
        check("post_rst_miso", miso_w[0], 32'h5A5A_5A5A);
        check("post_rst_rx", rx_data_o, 32'hF00D_FACE);

        wait_clk(20);
        check("rx_queue_drained", exp_rx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
